uadder_sched: RTL and testbench

- Sequencer and round-robin arbiter that shares one multi-cycle `uadder` (WADD-bit slice per cycle, NCYC cycles per operation) among NREQ requesters, e.g. PC increment, ALU add/sub and branch compare.
- Accepts one request at a time and drives the adder's `start`/`op`/operands for exactly NCYC cycles.
- Captures `out`/`cout`, derives the branch condition and returns the result with the requester ID over a valid/ready handshake.

---
 rtl/uadder_pkg.sv | 30 +++
 rtl/uadder_sched_rr_arbiter.sv | 35 +++
 rtl/uadder_sched.sv | 140 ++++++++++++++
 tb/tb_uadder_sched.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uadder_pkg.sv
// Shared types for the multi-cycle adder and its request scheduler.
// Also holds the scheduler FSM encoding and a small helper used to derive the branch flag.
package uadder_pkg;

  // Adder operations.
  // For the compare ops, bit 0 set marks the inverted form of the raw condition
  // (NE vs EQ, GE vs LT, GEU vs LTU).
  typedef enum logic [2:0] {
    ADDER_ADD = 3'b000,
    ADDER_SUB = 3'b001,
    ADDER_EQ  = 3'b010,
    ADDER_NE  = 3'b011,
    ADDER_LT  = 3'b100,
    ADDER_GE  = 3'b101,
    ADDER_LTU = 3'b110,
    ADDER_GEU = 3'b111
  } adderOp_t;

  // Scheduler FSM states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_CAPT = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  // True for every op whose flag is a branch condition rather than a carry
  function automatic logic op_is_cmp(input adderOp_t op);
    return (op != ADDER_ADD) && (op != ADDER_SUB);
  endfunction

endpackage

// File: rtl/uadder_sched_rr_arbiter.sv
// Combinational round-robin arbiter.
// It grants the first requesting index at or after ptr, wrapping at N.
// The pointer register lives in the parent, so this block holds no state.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  grant
);

  logic          found;
  logic [PW:0]   sum;
  logic [PW-1:0] idx;

  // Scan from ptr upward with wrap-around and grant the first requester found
  always_comb begin
    grant = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      sum = {1'b0, ptr} + (PW + 1)'(i);
      if (sum >= (PW + 1)'(N)) sum = sum - (PW + 1)'(N);
      idx = sum[PW-1:0];
      if (en && !found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uadder_sched.sv
// Scheduler that shares one multi-cycle uadder among NREQ requesters.
// It accepts one request at a time and holds start high for NCYC cycles.
// It then captures the sum and flag and returns them with the owner's ID
// over a valid/ready handshake.
module uadder_sched
  import uadder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int WADD  = 12,
  parameter int NREQ  = 3,
  localparam int NCYC = (WIDTH + WADD - 1) / WADD,
  localparam int WID  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [3*NREQ-1:0]     req_op,
  input  logic [WIDTH*NREQ-1:0] req_a,
  input  logic [WIDTH*NREQ-1:0] req_b,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [WID-1:0]        resp_id,
  output logic [WIDTH-1:0]      resp_data,
  output logic                  resp_flag,
  output logic                  add_start,
  output logic [2:0]            add_op,
  output logic [WIDTH-1:0]      add_a,
  output logic [WIDTH-1:0]      add_b,
  input  logic [WIDTH-1:0]      add_out,
  input  logic                  add_cout
);

  localparam int CW = (NCYC > 1) ? $clog2(NCYC) : 1;

  logic [1:0]       state;
  logic [CW-1:0]    count;
  logic [WID-1:0]   rr_ptr;
  logic [WID-1:0]   id_q;
  adderOp_t         op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] data_q;
  logic             flag_q;

  logic [NREQ-1:0]  grant;
  logic             arb_en;
  logic [WID-1:0]   win_id;
  logic [2:0]       win_op;
  logic [WIDTH-1:0] win_a;
  logic [WIDTH-1:0] win_b;

  // Grants are only offered in IDLE and never while reset is held,
  // so a requester can't see a ready that the FSM then ignores.
  assign arb_en = (state == ST_IDLE) && !rst;

  rr_arbiter #(
    .N  (NREQ),
    .PW (WID)
  ) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .en    (arb_en),
    .grant (grant)
  );

  assign req_ready  = grant;
  assign add_start  = (state == ST_RUN);
  assign add_op     = op_q;
  assign add_a      = a_q;
  assign add_b      = b_q;
  assign resp_valid = (state == ST_RESP);
  assign resp_id    = id_q;
  assign resp_data  = data_q;
  assign resp_flag  = flag_q;

  // Encode the one-hot grant and mux out the winner's payload
  always_comb begin
    win_id = '0;
    win_op = '0;
    win_a  = '0;
    win_b  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        win_id = WID'(i);
        win_op = req_op[3*i +: 3];
        win_a  = req_a[WIDTH*i +: WIDTH];
        win_b  = req_b[WIDTH*i +: WIDTH];
      end
    end
  end

  // Sequencer: accept, drive the adder NCYC cycles, capture, then hold the response
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      count  <= '0;
      rr_ptr <= '0;
      id_q   <= '0;
      op_q   <= ADDER_ADD;
      a_q    <= '0;
      b_q    <= '0;
      data_q <= '0;
      flag_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|grant) begin
            op_q  <= adderOp_t'(win_op);
            a_q   <= win_a;
            b_q   <= win_b;
            id_q  <= win_id;
            count <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (count == CW'(NCYC - 1)) begin
            count <= '0;
            state <= ST_CAPT;
          end else begin
            count <= count + 1'b1;
          end
        end
        ST_CAPT: begin
          data_q <= add_out;
          flag_q <= op_is_cmp(op_q) ? (add_cout ^ op_q[0]) : add_cout;
          state  <= ST_RESP;
        end
        default: begin
          if (resp_ready) begin
            rr_ptr <= (id_q == WID'(NREQ - 1)) ? '0 : id_q + 1'b1;
            state  <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uadder_sched.sv
// Self-checking bench for uadder_sched.
// A stub multi-cycle adder stands in for uadder.
// Expected results come from a plain arithmetic model of each operation.
module tb_uadder_sched;
  import uadder_pkg::*;

  localparam int WIDTH = 32;
  localparam int WADD  = 12;
  localparam int NREQ  = 3;
  localparam int NCYC  = (WIDTH + WADD - 1) / WADD;
  localparam int WID   = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [3*NREQ-1:0]     req_op;
  logic [WIDTH*NREQ-1:0] req_a;
  logic [WIDTH*NREQ-1:0] req_b;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [WID-1:0]        resp_id;
  logic [WIDTH-1:0]      resp_data;
  logic                  resp_flag;
  logic                  add_start;
  logic [2:0]            add_op;
  logic [WIDTH-1:0]      add_a;
  logic [WIDTH-1:0]      add_b;
  logic [WIDTH-1:0]      add_out;
  logic                  add_cout;

  int tests_run    = 0;
  int tests_failed = 0;
  int stub_cnt;

  uadder_sched #(.WIDTH(WIDTH), .WADD(WADD), .NREQ(NREQ)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_data(resp_data), .resp_flag(resp_flag),
    .add_start(add_start), .add_op(add_op), .add_a(add_a), .add_b(add_b),
    .add_out(add_out), .add_cout(add_cout)
  );

  always #5 clk = ~clk;

  // Stub adder: full result only after NCYC start cycles, junk in between
  function automatic logic [WIDTH:0] stub_full(input logic [2:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH:0] s;
    case (op)
      3'b000:  s = {1'b0, a} + {1'b0, b};
      3'b001:  s = {1'b0, a} + {1'b0, ~b} + 33'd1;
      default: begin
        s[WIDTH-1:0] = a - b;
        case (op[2:1])
          2'b01:   s[WIDTH] = (a == b);
          2'b10:   s[WIDTH] = ($signed(a) < $signed(b));
          default: s[WIDTH] = (a < b);
        endcase
      end
    endcase
    return s;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      stub_cnt <= 0;
      add_out  <= '0;
      add_cout <= 1'b0;
    end else if (add_start) begin
      if (stub_cnt == NCYC - 1) begin
        stub_cnt            <= 0;
        {add_cout, add_out} <= stub_full(add_op, add_a, add_b);
      end else begin
        stub_cnt <= stub_cnt + 1;
        add_out  <= 32'hDEAD_0000 | 32'(stub_cnt);
        add_cout <= ~add_cout;
      end
    end
  end

  // Reference model: what the requester should get back
  function automatic logic [WIDTH-1:0] ref_data(input logic [2:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return (op == ADDER_ADD) ? a + b : a - b;
  endfunction

  function automatic logic ref_flag(input logic [2:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    case (op)
      ADDER_ADD: return a > ~b;
      ADDER_SUB: return a >= b;
      ADDER_EQ:  return a == b;
      ADDER_NE:  return a != b;
      ADDER_LT:  return $signed(a) < $signed(b);
      ADDER_GE:  return $signed(a) >= $signed(b);
      ADDER_LTU: return a < b;
      default:   return a >= b;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic [2:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req_op[3*id +: 3]         = op;
    req_a[WIDTH*id +: WIDTH]  = a;
    req_b[WIDTH*id +: WIDTH]  = b;
    req_valid[id]             = 1'b1;
  endtask

  // Drives one request to completion and reports what was observed
  task automatic run_one(input int id, input logic [2:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input int hold, output bit ok, output logic [NREQ-1:0] gnt, output logic [WIDTH-1:0] d,
                         output logic f, output logic [WID-1:0] rid, output int starts, output int first,
                         output int last, output int lat);
    int w;
    ok = 1'b0; gnt = '0; d = '0; f = 1'b0; rid = '0; starts = 0; first = -1; last = -1; lat = 0;
    set_req(id, op, a, b);
    #1;
    w = 0;
    while (req_ready == '0 && w < 20) begin tick(); w++; end
    gnt = req_ready;
    if (req_ready == '0) begin req_valid[id] = 1'b0; return; end
    tick();
    req_valid[id] = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      if (add_start) begin starts++; if (first < 0) first = lat; last = lat; end
      tick();
      lat++;
    end
    if (!resp_valid) return;
    ok = 1'b1; d = resp_data; f = resp_flag; rid = resp_id;
    repeat (hold) tick();
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '1;
    repeat (3) tick();
    tests_run++; if (req_ready !== '0) begin tests_failed++; $display("[TB] FAIL reset_req_ready: got %b want 000", req_ready); end
    tests_run++; if (add_start !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_add_start: got %b want 0", add_start); end
    tests_run++; if (resp_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_resp_valid: got %b want 0", resp_valid); end
    tests_run++; if (add_op !== ADDER_ADD) begin tests_failed++; $display("[TB] FAIL reset_add_op: got %0d want 0", add_op); end
    tests_run++; if (add_a !== '0 || add_b !== '0) begin tests_failed++; $display("[TB] FAIL reset_add_ab: got %h/%h want 0/0", add_a, add_b); end
    tests_run++; if (resp_data !== '0 || resp_id !== '0 || resp_flag !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL reset_resp_payload: got %h/%0d/%b want 0/0/0", resp_data, resp_id, resp_flag); end
    req_valid = '0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_add();
    bit ok; logic [NREQ-1:0] g; logic [WIDTH-1:0] d; logic f; logic [WID-1:0] rid; int st, fi, la, lat;
    run_one(0, ADDER_ADD, 32'h0000_0001, 32'hFFFF_FFFF, 0, ok, g, d, f, rid, st, fi, la, lat);
    tests_run++; if (!ok) begin tests_failed++; $display("[TB] FAIL add_timeout: got no response want response"); end
    tests_run++; if (g !== 3'b001) begin tests_failed++; $display("[TB] FAIL add_grant: got %b want 001", g); end
    tests_run++; if (st != NCYC || fi != 1 || la != NCYC) begin
      tests_failed++; $display("[TB] FAIL add_start_window: got %0d starts at %0d..%0d want %0d at 1..%0d", st, fi, la, NCYC, NCYC); end
    tests_run++; if (lat != NCYC + 2) begin tests_failed++; $display("[TB] FAIL add_latency: got %0d want %0d", lat, NCYC + 2); end
    tests_run++; if (d !== 32'h0 || f !== 1'b1 || rid !== 2'd0) begin
      tests_failed++; $display("[TB] FAIL add_result: got %h/%b/%0d want 0/1/0", d, f, rid); end
  endtask

  task automatic test_compare();
    bit ok; logic [NREQ-1:0] g; logic [WIDTH-1:0] d; logic f; logic [WID-1:0] rid; int st, fi, la, lat;
    run_one(2, ADDER_GE, 32'd5, 32'd7, 1, ok, g, d, f, rid, st, fi, la, lat);
    tests_run++; if (!ok || f !== 1'b0 || rid !== 2'd2 || d !== 32'hFFFF_FFFE) begin
      tests_failed++; $display("[TB] FAIL cmp_ge: got ok=%b %h/%b/%0d want ok=1 fffffffe/0/2", ok, d, f, rid); end
    run_one(2, ADDER_LT, 32'd5, 32'd7, 0, ok, g, d, f, rid, st, fi, la, lat);
    tests_run++; if (!ok || f !== 1'b1 || rid !== 2'd2) begin
      tests_failed++; $display("[TB] FAIL cmp_lt: got ok=%b %b/%0d want ok=1 1/2", ok, f, rid); end
  endtask

  task automatic test_random();
    bit ok; logic [NREQ-1:0] g; logic [WIDTH-1:0] d, a, b; logic f; logic [WID-1:0] rid; int st, fi, la, lat, id;
    logic [2:0] op;
    for (int n = 0; n < 16; n++) begin
      id = $urandom_range(0, NREQ - 1);
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
      run_one(id, op, a, b, $urandom_range(0, 3), ok, g, d, f, rid, st, fi, la, lat);
      tests_run++; if (!ok || g !== (NREQ'(1) << id)) begin
        tests_failed++; $display("[TB] FAIL rand%0d_grant: got ok=%b grant=%b want ok=1 grant for %0d", n, ok, g, id); end
      tests_run++; if (d !== ref_data(op, a, b) || f !== ref_flag(op, a, b) || rid !== WID'(id)) begin
        tests_failed++; $display("[TB] FAIL rand%0d_result op=%0d a=%h b=%h: got %h/%b/%0d want %h/%b/%0d",
                                 n, op, a, b, d, f, rid, ref_data(op, a, b), ref_flag(op, a, b), id); end
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] pop[NREQ]; logic [WIDTH-1:0] pa[NREQ]; logic [WIDTH-1:0] pb[NREQ];
    logic [WIDTH-1:0] exp_d; logic exp_f; int mptr, exp_id, c, w;
    rst = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      pop[i] = 3'($urandom_range(0, 7)); pa[i] = $urandom; pb[i] = $urandom;
      set_req(i, pop[i], pa[i], pb[i]);
    end
    tick(); tick();
    rst = 1'b0;
    mptr = 0;
    for (int gidx = 0; gidx < 2 * NREQ; gidx++) begin
      #1;
      w = 0;
      while (req_ready == '0 && w < 20) begin tick(); w++; end
      exp_id = -1;
      for (int k = 0; k < NREQ; k++) begin
        c = (mptr + k) % NREQ;
        if (exp_id < 0 && req_valid[c]) exp_id = c;
      end
      tests_run++; if (req_ready !== (NREQ'(1) << exp_id)) begin
        tests_failed++; $display("[TB] FAIL rr_grant%0d: got %b want requester %0d", gidx, req_ready, exp_id); end
      exp_d = ref_data(pop[exp_id], pa[exp_id], pb[exp_id]);
      exp_f = ref_flag(pop[exp_id], pa[exp_id], pb[exp_id]);
      tick();
      pop[exp_id] = 3'($urandom_range(0, 7)); pa[exp_id] = $urandom; pb[exp_id] = $urandom;
      set_req(exp_id, pop[exp_id], pa[exp_id], pb[exp_id]);
      w = 0;
      while (!resp_valid && w < 20) begin tick(); w++; end
      tests_run++; if (!resp_valid || resp_id !== WID'(exp_id) || resp_data !== exp_d || resp_flag !== exp_f) begin
        tests_failed++; $display("[TB] FAIL rr_resp%0d: got v=%b %0d/%h/%b want 1 %0d/%h/%b",
                                 gidx, resp_valid, resp_id, resp_data, resp_flag, exp_id, exp_d, exp_f); end
      resp_ready = 1'b1; tick(); resp_ready = 1'b0;
      mptr = (exp_id + 1) % NREQ;
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_stall_wait();
    logic [WIDTH-1:0] a0, b0, a1, b1, e0; int w, busy_bad;
    a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
    e0 = a0 + b0;
    set_req(0, ADDER_ADD, a0, b0);
    #1;
    tests_run++; if (req_ready !== 3'b001) begin tests_failed++; $display("[TB] FAIL stall_accept: got %b want 001", req_ready); end
    tick();
    req_valid[0] = 1'b0;
    set_req(1, ADDER_SUB, a1, b1);
    #1;
    w = 0; busy_bad = 0;
    while (!resp_valid && w < 20) begin
      if (req_ready !== '0) busy_bad++;
      tick(); w++;
    end
    tests_run++; if (busy_bad != 0 || !resp_valid) begin
      tests_failed++; $display("[TB] FAIL busy_no_ready: got %0d ready cycles, v=%b want 0, v=1", busy_bad, resp_valid); end
    for (int k = 0; k < 10; k++) begin
      tests_run++; if (resp_valid !== 1'b1 || resp_data !== e0 || resp_id !== 2'd0 || resp_flag !== (a0 > ~b0)) begin
        tests_failed++; $display("[TB] FAIL stall%0d_payload: got %b %h/%0d/%b want 1 %h/0/%b",
                                 k, resp_valid, resp_data, resp_id, resp_flag, e0, (a0 > ~b0)); end
      tests_run++; if (add_start !== 1'b0 || req_ready !== '0) begin
        tests_failed++; $display("[TB] FAIL stall%0d_quiet: got start=%b ready=%b want 0/000", k, add_start, req_ready); end
      tick();
    end
    resp_ready = 1'b1; tick(); resp_ready = 1'b0;
    #1;
    tests_run++; if (resp_valid !== 1'b0 || req_ready !== 3'b010) begin
      tests_failed++; $display("[TB] FAIL release_idle: got v=%b ready=%b want 0/010", resp_valid, req_ready); end
    tick();
    req_valid[1] = 1'b0;
    w = 0;
    while (!resp_valid && w < 20) begin tick(); w++; end
    tests_run++; if (!resp_valid || resp_data !== a1 - b1 || resp_flag !== (a1 >= b1) || resp_id !== 2'd1) begin
      tests_failed++; $display("[TB] FAIL waiter_result: got v=%b %h/%b/%0d want 1 %h/%b/1",
                               resp_valid, resp_data, resp_flag, resp_id, a1 - b1, (a1 >= b1)); end
    resp_ready = 1'b1; tick(); resp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    logic [WIDTH-1:0] a1, b1, a2, b2; int w, st;
    a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = a2;
    set_req(0, ADDER_ADD, $urandom, $urandom);
    #1;
    tick();
    req_valid[0] = 1'b0;
    set_req(1, ADDER_ADD, a1, b1);
    set_req(2, ADDER_NE, a2, b2);
    tick();
    rst = 1'b1;
    tick();
    tests_run++; if (add_start !== 1'b0 || resp_valid !== 1'b0 || req_ready !== '0) begin
      tests_failed++; $display("[TB] FAIL midrst_idle: got start=%b v=%b ready=%b want 0/0/000", add_start, resp_valid, req_ready); end
    rst = 1'b0;
    #1;
    tests_run++; if (req_ready !== 3'b010) begin tests_failed++; $display("[TB] FAIL midrst_regrant: got %b want 010", req_ready); end
    tick();
    req_valid[1] = 1'b0;
    w = 0; st = 0;
    while (!resp_valid && w < 20) begin if (add_start) st++; tick(); w++; end
    tests_run++; if (!resp_valid || st != NCYC || resp_data !== a1 + b1 || resp_id !== 2'd1 || resp_flag !== (a1 > ~b1)) begin
      tests_failed++; $display("[TB] FAIL midrst_result: got v=%b starts=%0d %h/%0d want 1 %0d %h/1",
                               resp_valid, st, resp_data, resp_id, NCYC, a1 + b1); end
    resp_ready = 1'b1; tick(); resp_ready = 1'b0;
    #1;
    tests_run++; if (req_ready !== 3'b100) begin tests_failed++; $display("[TB] FAIL midrst_next: got %b want 100", req_ready); end
    tick();
    req_valid[2] = 1'b0;
    w = 0;
    while (!resp_valid && w < 20) begin tick(); w++; end
    tests_run++; if (!resp_valid || resp_flag !== 1'b0 || resp_id !== 2'd2 || resp_data !== 32'h0) begin
      tests_failed++; $display("[TB] FAIL midrst_ne: got v=%b %h/%b/%0d want 1 0/0/2", resp_valid, resp_data, resp_flag, resp_id); end
    resp_ready = 1'b1; tick(); resp_ready = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = '0;
    req_op     = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b0;
    test_reset();
    test_single_add();
    test_compare();
    test_random();
    test_round_robin();
    test_stall_wait();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
